traffic_phase_fsm: RTL

- Downstream consumer of the one-second tick produced by the existing phase counter.
- Sequences a two-road intersection (NS/EW) through green, yellow and all-red phases, with dwell times counted in ticks.
- Latches pedestrian requests and cuts the current green short once the minimum green has elapsed.
- Has a flash (fault/maintenance) mode that blinks both yellows.

---
 rtl/traffic_phase_fsm_pkg.sv | 55 +++++
 rtl/traffic_phase_fsm_if.sv | 38 +++
 rtl/traffic_phase_fsm_dwell_counter.sv | 47 ++++
 rtl/traffic_phase_fsm.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/traffic_phase_fsm_pkg.sv
// traffic_pkg: shared definitions for the intersection phase sequencer.
//   - phase_t / light_t  : 3-bit phase encoding and {R,Y,G} light code types
//   - phase constants    : NS_GREEN..FLASH, fixed numeric encodings seen on the phase output
//   - light constants    : RED, YEL, GRN, OFF
//   - DEF_* constants    : default dwell durations and counter width
//   - next_phase()       : successor in the normal (non-flash) cycle
//   - is_green()/is_yellow() : phase class helpers
package traffic_pkg;

    typedef logic [2:0] phase_t;
    typedef logic [2:0] light_t;

    localparam phase_t NS_GREEN  = 3'd0;
    localparam phase_t NS_YELLOW = 3'd1;
    localparam phase_t ALLRED_A  = 3'd2;
    localparam phase_t EW_GREEN  = 3'd3;
    localparam phase_t EW_YELLOW = 3'd4;
    localparam phase_t ALLRED_B  = 3'd5;
    localparam phase_t FLASH     = 3'd6;

    localparam light_t RED = 3'b100;
    localparam light_t YEL = 3'b010;
    localparam light_t GRN = 3'b001;
    localparam light_t OFF = 3'b000;

    localparam int unsigned DEF_GREEN_TICKS     = 30;
    localparam int unsigned DEF_YELLOW_TICKS    = 3;
    localparam int unsigned DEF_ALLRED_TICKS    = 1;
    localparam int unsigned DEF_MIN_GREEN_TICKS = 10;
    localparam int unsigned DEF_CNT_W           = 6;

    function automatic phase_t next_phase(input phase_t st);
        phase_t nxt;
        case (st)
            NS_GREEN:  nxt = NS_YELLOW;
            NS_YELLOW: nxt = ALLRED_A;
            ALLRED_A:  nxt = EW_GREEN;
            EW_GREEN:  nxt = EW_YELLOW;
            EW_YELLOW: nxt = ALLRED_B;
            ALLRED_B:  nxt = NS_GREEN;
            // FLASH never uses the normal successor; clearance is the safe fallback.
            default:   nxt = ALLRED_B;
        endcase
        return nxt;
    endfunction

    function automatic logic is_green(input phase_t st);
        return (st == NS_GREEN) || (st == EW_GREEN);
    endfunction

    function automatic logic is_yellow(input phase_t st);
        return (st == NS_YELLOW) || (st == EW_YELLOW);
    endfunction

endpackage

// File: rtl/traffic_phase_fsm_if.sv
// traffic_phase_fsm_if: request/status bundle of the phase sequencer.
//   tick, ped_req, flash                           : inputs to the sequencer
//   ns_light, ew_light, phase, phase_done, ped_pending : sequencer status
// master drives the inputs and observes status; slave is the sequencer side.
interface traffic_phase_fsm_if;

    logic       tick;
    logic       ped_req;
    logic       flash;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic       phase_done;
    logic       ped_pending;

    modport master (
        output tick,
        output ped_req,
        output flash,
        input  ns_light,
        input  ew_light,
        input  phase,
        input  phase_done,
        input  ped_pending
    );

    modport slave (
        input  tick,
        input  ped_req,
        input  flash,
        output ns_light,
        output ew_light,
        output phase,
        output phase_done,
        output ped_pending
    );

endinterface

// File: rtl/traffic_phase_fsm_dwell_counter.sv
// phase_dwell_counter: tick-driven dwell counter for one phase.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clear_i         : return count to zero (phase change); wins over tick_i
//   tick_i          : advance count by one
//   dur_i           : dwell of the current phase in ticks (>= 1)
//   min_i           : minimum dwell before an early exit is allowed (>= 1)
//   cnt_o           : current count
//   expire_o        : count is on its last tick of the phase
//   min_reached_o   : the next tick completes at least min_i ticks
module phase_dwell_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] dur_i,
    input  logic [CNT_W-1:0] min_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             expire_o,
    output logic             min_reached_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o         = cnt_q;
    assign expire_o      = (cnt_q == dur_i - CNT_W'(1));
    assign min_reached_o = (cnt_q >= min_i - CNT_W'(1));

endmodule

// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm: two-road (NS/EW) intersection phase sequencer.
//   clk_out : system clock
//   reset   : asynchronous active-low reset
//   bus     : traffic_phase_fsm_if.slave
//     tick        in  one-cycle strobe; all dwell timing advances on it
//     ped_req     in  pedestrian button (level or pulse)
//     flash       in  forces flash mode while high
//     ns_light    out {R,Y,G} for NS road
//     ew_light    out {R,Y,G} for EW road
//     phase       out current phase encoding
//     phase_done  out one-cycle pulse after any phase change
//     ped_pending out latched pedestrian request
module traffic_phase_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_TICKS     = DEF_GREEN_TICKS,
    parameter int unsigned YELLOW_TICKS    = DEF_YELLOW_TICKS,
    parameter int unsigned ALLRED_TICKS    = DEF_ALLRED_TICKS,
    parameter int unsigned MIN_GREEN_TICKS = DEF_MIN_GREEN_TICKS,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic               clk_out,
    input  logic               reset,
    traffic_phase_fsm_if.slave bus
);

    localparam logic [CNT_W-1:0] GreenDur  = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] YellowDur = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] AllredDur = CNT_W'(ALLRED_TICKS);
    localparam logic [CNT_W-1:0] MinGreen  = CNT_W'(MIN_GREEN_TICKS);

    phase_t           state_q, state_d;
    logic             flash_phase_q, flash_phase_d;
    logic             ped_pending_q, ped_pending_d;
    logic             phase_done_q;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] cnt;
    logic             expire;
    logic             min_reached;
    logic             state_change;
    logic             enter_yellow;
    logic             dwell_tick;
    light_t           ns_light;
    light_t           ew_light;

    // Dwell of the current phase; FLASH reports 1 so cnt (held at 0) stays in range.
    always_comb begin
        dur = CNT_W'(1);
        unique case (state_q)
            NS_GREEN, EW_GREEN:   dur = GreenDur;
            NS_YELLOW, EW_YELLOW: dur = YellowDur;
            ALLRED_A, ALLRED_B:   dur = AllredDur;
            default:              dur = CNT_W'(1);
        endcase
    end

    // The counter does not run in FLASH; ticks there only drive the blink.
    assign dwell_tick = bus.tick && (state_q != FLASH);

    phase_dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk_i         (clk_out),
        .rst_ni        (reset),
        .clear_i       (state_change),
        .tick_i        (dwell_tick),
        .dur_i         (dur),
        .min_i         (MinGreen),
        .cnt_o         (cnt),
        .expire_o      (expire),
        .min_reached_o (min_reached)
    );

    // flash outranks every timed or pedestrian transition.
    always_comb begin
        state_d       = state_q;
        flash_phase_d = flash_phase_q;
        if (bus.flash) begin
            if (state_q != FLASH) begin
                state_d       = FLASH;
                flash_phase_d = 1'b0;
            end else if (bus.tick) begin
                flash_phase_d = ~flash_phase_q;
            end
        end else if (state_q == FLASH) begin
            // Leave through clearance so both roads show red before any green.
            state_d       = ALLRED_B;
            flash_phase_d = 1'b0;
        end else if (bus.tick) begin
            if (expire || (is_green(state_q) && ped_pending_q && min_reached)) begin
                state_d = next_phase(state_q);
            end
        end
    end

    assign state_change = (state_d != state_q);
    assign enter_yellow = state_change && is_yellow(state_d);

    // A request arriving on the clearing edge survives for the next green.
    assign ped_pending_d = bus.ped_req | (ped_pending_q & ~enter_yellow);

    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            state_q       <= NS_GREEN;
            flash_phase_q <= 1'b0;
            ped_pending_q <= 1'b0;
            phase_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            flash_phase_q <= flash_phase_d;
            ped_pending_q <= ped_pending_d;
            phase_done_q  <= state_change;
        end
    end

    // Moore decode straight off the state register.
    always_comb begin
        ns_light = RED;
        ew_light = RED;
        unique case (state_q)
            NS_GREEN:  begin ns_light = GRN; ew_light = RED; end
            NS_YELLOW: begin ns_light = YEL; ew_light = RED; end
            ALLRED_A:  begin ns_light = RED; ew_light = RED; end
            EW_GREEN:  begin ns_light = RED; ew_light = GRN; end
            EW_YELLOW: begin ns_light = RED; ew_light = YEL; end
            ALLRED_B:  begin ns_light = RED; ew_light = RED; end
            FLASH: begin
                ns_light = flash_phase_q ? YEL : OFF;
                ew_light = flash_phase_q ? YEL : OFF;
            end
            default:   begin ns_light = RED; ew_light = RED; end
        endcase
    end

    assign bus.ns_light    = ns_light;
    assign bus.ew_light    = ew_light;
    assign bus.phase       = state_q;
    assign bus.phase_done  = phase_done_q;
    assign bus.ped_pending = ped_pending_q;

`ifndef SYNTHESIS
    a_cnt_in_range: assert property (@(posedge clk_out) disable iff (!reset) cnt < dur);
    a_no_dual_green: assert property (@(posedge clk_out) disable iff (!reset)
        !(ns_light == GRN && ew_light == GRN));
    a_one_road_red: assert property (@(posedge clk_out) disable iff (!reset)
        (state_q == FLASH) || (ns_light == RED) || (ew_light == RED));
`endif

endmodule
